// File: rtl/rd_data_buffer_if.sv
// rd_data_buffer_if: AXI read-data channel plus buffered output stream.
//   m_axi_rid/rdata/rresp/rlast/rvalid : read beat from the AXI read master
//   m_axi_rready                       : beat accept back to the AXI side
//   o_valid/o_data/o_last              : head of the beat FIFO
//   o_ready                            : consumer accept
// slave  = the buffer (consumes R beats, produces the stream)
// master = the surrounding environment
interface rd_data_buffer_if #(
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 512
);
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;
    logic                  o_ready;
    modport slave (
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, o_ready,
        output m_axi_rready, o_valid, o_data, o_last
    );
    modport master (
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, o_ready,
        input  m_axi_rready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/rd_data_buffer.sv
// rd_data_buffer: buffers AXI read beats in a first-word-fall-through FIFO,
// checks rresp and burst framing, and pulses done once all beats drained.
//   clk, rst           : clock, synchronous active-high reset
//   bus                : R channel in, valid/ready beat stream out
//   engine_start_pulse : one-cycle start (honoured only in IDLE)
//   rd_len             : AXI len per burst (beats-1), latched on start
//   total_beat_count   : expected beats, latched on start
//   buf_done_pulse     : one-cycle completion pulse
//   buf_error          : sticky {framing, bad rresp}
//   buf_error_info     : {rid[7:0], rresp, 6'b0, burst_beat, beat index} of first error
//   stall_count        : rvalid && !rready cycles in RUN; built only when
//                        RDBUF_STALL_CNT_EN is defined, otherwise 0
module rd_data_buffer #(
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                clk,
    input  logic                rst,
    rd_data_buffer_if.slave     bus,
    input  logic                engine_start_pulse,
    input  logic [7:0]          rd_len,
    input  logic [39:0]         total_beat_count,
    output logic                buf_done_pulse,
    output logic [1:0]          buf_error,
    output logic [63:0]         buf_error_info,
    output logic [31:0]         stall_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    state_t                state_q, state_d;
    logic [DATA_WIDTH:0]   mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  rready_q, zero_done_q;
    logic [39:0]           total_q, accepted_q;
    logic [7:0]            rd_len_q, burst_q;
    logic [1:0]            err_q, err_new;
    logic [63:0]           info_q;
    logic                  head_valid, push, pop, start_ok, last_beat, frame_err;

    assign head_valid     = count_q != '0;
    assign push           = bus.m_axi_rvalid && rready_q;
    assign pop            = head_valid && bus.o_ready;
    assign start_ok       = state_q == IDLE && engine_start_pulse;
    assign last_beat      = accepted_q + 40'd1 == total_q;
    assign frame_err      = bus.m_axi_rlast ? burst_q != rd_len_q : burst_q == rd_len_q;
    assign err_new        = {frame_err, bus.m_axi_rresp != 2'b00};
    assign count_d        = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    assign bus.m_axi_rready = rready_q;
    assign bus.o_valid    = head_valid;
    assign bus.o_data     = head_valid ? mem_q[rptr_q][DATA_WIDTH-1:0] : '0;
    assign bus.o_last     = head_valid && mem_q[rptr_q][DATA_WIDTH];
    assign buf_done_pulse = state_q == DONE || zero_done_q;
    assign buf_error      = err_q;
    assign buf_error_info = info_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start_ok && total_beat_count != '0) ? RUN : IDLE;
            RUN:     state_d = (push && last_beat) ? DRAIN : RUN;
            DRAIN:   state_d = (count_d == '0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Storage has no reset: emptiness is tracked purely by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.m_axi_rlast, bus.m_axi_rdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rready_q    <= 1'b0;
            zero_done_q <= 1'b0;
            total_q     <= '0;
            accepted_q  <= '0;
            rd_len_q    <= '0;
            burst_q     <= '0;
            err_q       <= '0;
            info_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            // Derived from next-state occupancy so ready never survives into a full cycle.
            rready_q    <= state_d == RUN && count_d != FULL;
            zero_done_q <= start_ok && total_beat_count == '0;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (start_ok) begin
                total_q    <= total_beat_count;
                rd_len_q   <= rd_len;
                accepted_q <= '0;
                burst_q    <= '0;
                err_q      <= '0;
                info_q     <= '0;
            end else if (push) begin
                accepted_q <= accepted_q + 40'd1;
                burst_q    <= bus.m_axi_rlast ? 8'd0 : burst_q + 8'd1;
                err_q      <= err_q | err_new;
                if (err_q == '0 && err_new != '0)
                    info_q <= {8'(bus.m_axi_rid), bus.m_axi_rresp, 6'b0, burst_q, accepted_q};
            end
        end
    end

`ifdef RDBUF_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst || start_ok) stall_q <= '0;
        else if (state_q == RUN && bus.m_axi_rvalid && !rready_q && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_rd_data_buffer.sv
// tb_rd_data_buffer: randomized scoreboard bench for rd_data_buffer.
module tb_rd_data_buffer;
    localparam int IDW = 2;
    localparam int DW  = 512;
    localparam int DL  = 5;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rd_len = '0;
    logic [39:0] total = '0;
    logic        done;
    logic [1:0]  err;
    logic [63:0] info;
    logic [31:0] stall;

    always #5 clk = ~clk;

    rd_data_buffer_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

    rd_data_buffer #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .engine_start_pulse(start), .rd_len(rd_len), .total_beat_count(total),
        .buf_done_pulse(done), .buf_error(err), .buf_error_info(info), .stall_count(stall)
    );

    beat_t       sbq[$];
    int          checks = 0, failures = 0, mchecks = 0, mfails = 0, done_cnt = 0;
    int          ready_mode = 1;
    int          stall_exp = 0;
    logic [1:0]  exp_err;
    logic [63:0] exp_info;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // consumer side
    initial begin
        bus.o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.o_ready = ready_mode == 0 ? 1'b0 : ready_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // monitor: pops the scoreboard on every output handshake
    logic [DW-1:0] prev_d;
    logic          prev_hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                mchecks++;
                if (!bus.o_valid || bus.o_data !== prev_d) begin
                    mfails++;
                    $display("FAIL hold: valid=%0b data changed while stalled", bus.o_valid);
                end
            end
            prev_hold = bus.o_valid && !bus.o_ready;
            prev_d    = bus.o_data;
            if (bus.o_valid && bus.o_ready) begin
                mchecks++;
                if (sbq.size() == 0) begin
                    mfails++;
                    $display("FAIL beat: unexpected output beat last=%0b, expected none", bus.o_last);
                end else begin
                    beat_t b;
                    b = sbq.pop_front();
                    if (b.d !== bus.o_data || b.l !== bus.o_last) begin
                        mfails++;
                        $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                                 bus.o_last, bus.o_data[63:0], b.l, b.d[63:0]);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                mchecks++;
                if (sbq.size() != 0) begin
                    mfails++;
                    $display("FAIL done_early: %0d beats pending, expected 0", sbq.size());
                end
            end
        end
    end

    task automatic do_start(input logic [39:0] t, input logic [7:0] rl);
        @(posedge clk);
        #1;
        start = 1'b1; total = t; rd_len = rl;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one beat; hold>0 keeps it waiting that many cycles and then
    // checks the FIFO-full backpressure before letting the consumer drain.
    task automatic send_beat(input beat_t b, input logic [IDW-1:0] rid, input logic [1:0] resp, input int hold);
        int w = 0;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = b.d;
        bus.m_axi_rlast  = b.l;
        bus.m_axi_rid    = rid;
        bus.m_axi_rresp  = resp;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                if (!bus.m_axi_rready) stall_exp++;
            end
            chk("full_rready", 64'(bus.m_axi_rready), 64'd0);
            chk("full_level", 64'(sbq.size()), 64'd32);
            chk("full_valid", 64'(bus.o_valid), 64'd1);
            ready_mode = 1;
        end
        forever begin
            @(negedge clk);
            if (bus.m_axi_rready) break;
            stall_exp++;
            if (++w > 5000) break;
        end
        if (w > 5000) chk("rready_timeout", 64'(w), 64'd0);
        else sbq.push_back(b);
        @(posedge clk);
        #1;
        bus.m_axi_rvalid = 1'b0;
    endtask

    task automatic run_xfer(input int tot, input logic [7:0] rl, input int gap_max, input int err_pct,
                            input int inj_resp, input int inj_last, input int hold_at, input int restart_at);
        logic [7:0] pos = '0;
        int d0 = done_cnt;
        int w = 0;
        exp_err = '0; exp_info = '0; stall_exp = 0;
        do_start(40'(tot), rl);
        for (int i = 0; i < tot; i++) begin
            beat_t          b;
            logic [IDW-1:0] rid;
            logic [1:0]     resp;
            logic [1:0]     e;
            if (i == restart_at) do_start(40'd5, 8'd0);
            for (int k = 0; k < DW / 32; k++) b.d[k*32 +: 32] = $urandom;
            rid  = IDW'($urandom);
            resp = (i == inj_resp) ? 2'd2 : ($urandom_range(0, 99) < err_pct) ? 2'($urandom_range(1, 3)) : 2'd0;
            b.l  = (i == inj_last) ? 1'b1 : (pos == rl);
            if ($urandom_range(0, 99) < err_pct) b.l = ~b.l;
            e = {b.l ? pos != rl : pos == rl, resp != 2'd0};
            if (exp_err == '0 && e != '0) exp_info = {8'(rid), resp, 6'b0, pos, 40'(i)};
            exp_err = exp_err | e;
            send_beat(b, rid, resp, i == hold_at ? 40 : 0);
            pos = b.l ? 8'd0 : pos + 8'd1;
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #0;
        end
        while (done_cnt == d0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("drained", 64'(sbq.size()), 64'd0);
        chk("buf_error", 64'(err), 64'(exp_err));
        chk("buf_error_info", info, exp_info);
`ifdef RDBUF_STALL_CNT_EN
        chk("stall_count", 64'(stall), 64'(stall_exp));
`else
        chk("stall_count", 64'(stall), 64'd0);
`endif
        chk("idle_rready", 64'(bus.m_axi_rready), 64'd0);
    endtask

    initial begin
        int d0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = '0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rid    = '0;
        bus.m_axi_rresp  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rready", 64'(bus.m_axi_rready), 64'd0);
        chk("rst_ovalid", 64'(bus.o_valid), 64'd0);
        chk("rst_odata", bus.o_data[63:0], 64'd0);
        chk("rst_olast", 64'(bus.o_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_info", info, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;

        // four clean 8-beat bursts, with an ignored second start mid-run
        ready_mode = 1;
        run_xfer(32, 8'd7, 0, 0, -1, -1, -1, 12);
        // backpressure: FIFO fills to 32, then drains
        ready_mode = 0;
        run_xfer(64, 8'd7, 0, 0, -1, -1, 32, -1);
        // bad rresp on beat 5
        ready_mode = 2;
        run_xfer(16, 8'd7, 1, 0, 5, -1, -1, -1);
        // early rlast at burst beat 2 with len 3
        run_xfer(12, 8'd3, 1, 0, -1, 2, -1, -1);
        // randomized mixes
        for (int r = 0; r < 3; r++)
            run_xfer($urandom_range(1, 80), 8'($urandom_range(0, 7)), 2, 10, -1, -1, -1, -1);

        // zero-length start: done next cycle, never ready
        d0 = done_cnt;
        do_start(40'd0, 8'd7);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_rready", 64'(bus.m_axi_rready), 64'd0);
        @(negedge clk);
        chk("zero_done_off", 64'(done), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);

        // reset in the middle of a transfer
        ready_mode = 0;
        do_start(40'd40, 8'd7);
        for (int i = 0; i < 10; i++) begin
            beat_t b;
            for (int k = 0; k < DW / 32; k++) b.d[k*32 +: 32] = $urandom;
            b.l = i == 7;
            send_beat(b, '0, 2'd1, 0);
        end
        d0 = done_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_rready", 64'(bus.m_axi_rready), 64'd0);
        chk("mid_rst_ovalid", 64'(bus.o_valid), 64'd0);
        chk("mid_rst_odata", bus.o_data[63:0], 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_info", info, 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        sbq.delete();
        rst = 1'b0;
        ready_mode = 1;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_idle", 64'(bus.o_valid), 64'd0);

        checks   += mchecks;
        failures += mfails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rd_data_buffer.md
Name: rd_data_buffer

Overview:
- Sits directly downstream of the memcopy AXI read master on the AXI R channel.
- Accepts read-data beats, checks response and burst framing, and stores beats in a FIFO.
- Presents the beats as a valid/ready stream to the write-side data path.
- Emits one done pulse when all expected beats have been accepted and drained, and reports sticky errors.

Parameters:
- ID_WIDTH, 2: AXI ID width.
- DATA_WIDTH, 512: beat width.
- DEPTH_LOG2, 5: FIFO depth is 2^DEPTH_LOG2 beats.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_axi_rid  in  ID_WIDTH  read ID.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid  in  1  beat valid.
- m_axi_rready  out  1  beat accept.
- engine_start_pulse  in  1  one-cycle start.
- rd_len  in  8  AXI len per burst (beats-1).
- total_beat_count  in  40  expected beats; sampled on start.
- o_valid  out  1  FIFO head valid.
- o_data  out  DATA_WIDTH  FIFO head data.
- o_last  out  1  head beat was rlast.
- o_ready  in  1  consumer accept.
- buf_done_pulse  out  1  completion pulse.
- buf_error  out  2  bit0 = bad rresp, bit1 = framing error; sticky.
- buf_error_info  out  64  first-error capture.
- stall_count  out  32  backpressure cycle counter (see Optional Feature).

Behaviour:
- Reset (rst high at a clk edge) clears all state.
  - m_axi_rready=0, o_valid=0, o_data=0, o_last=0, buf_done_pulse=0, buf_error=0, buf_error_info=0, stall_count=0.
  - FIFO emptied; FSM returns to IDLE.
  - Reset mid-operation discards buffered beats; no done pulse is issued.
- FSM states:
  - IDLE -> RUN on engine_start_pulse when total_beat_count != 0. The start cycle latches total_beat_count and rd_len, and clears remaining, burst_beat, buf_error and buf_error_info.
  - Start with total_beat_count == 0: pulse buf_done_pulse the next cycle and stay in IDLE.
  - RUN -> DRAIN when the beat that makes accepted == total is taken.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -> IDLE after one cycle. buf_done_pulse=1 exactly in the DONE cycle.
  - engine_start_pulse outside IDLE is ignored.
- m_axi_rready:
  - In RUN: 1 iff FIFO occupancy < 2^DEPTH_LOG2. Registered from next-state occupancy, so it is never asserted while full.
  - In IDLE, DRAIN and DONE: 0.
- Push occurs on m_axi_rvalid && m_axi_rready. It stores rdata and rlast, decrements remaining (40-bit) and advances burst_beat (8-bit).
- Output side:
  - First-word fall-through: a beat pushed at edge N is visible on o_valid/o_data at cycle N+1.
  - Pop occurs on o_valid && o_ready.
  - o_data is held stable while o_valid && !o_ready.
  - Simultaneous push and pop leave occupancy unchanged. Occupancy counter is DEPTH_LOG2+1 bits. Read and write pointers wrap modulo depth.
- Framing check:
  - burst_beat resets to 0 after any beat with rlast.
  - Error if rlast=1 with burst_beat != rd_len.
  - Error if rlast=0 with burst_beat == rd_len.
  - Either case sets buf_error[1].
- Response check: rresp != 0 on an accepted beat sets buf_error[0].
- Error capture:
  - On the first error since start, buf_error_info = {rid zero-extended to 8, rresp 2, pad 6, burst_beat 8, accepted-beat index 40}.
  - Later errors update buf_error bits only.
- Errors do not stop the transfer; beats are still buffered and the done pulse still fires.

Optional Feature:
- Macro: RDBUF_STALL_CNT_EN.
- Defined:
  - stall_count increments (saturating at 0xFFFFFFFF) each cycle with m_axi_rvalid && !m_axi_rready while in RUN.
  - stall_count clears on accepted start.
- Undefined: stall_count tied to 0 and no counter logic is built.

Test Plan:
- Start, total=32, rd_len=7, four 8-beat bursts, o_ready=1 -> 32 beats out in order with o_last on beats 7/15/23/31; buf_done_pulse once, one cycle after the last pop; buf_error=0.
- DEPTH_LOG2=5, total=64, o_ready=0 -> m_axi_rready drops after 32 accepted beats, never overflows. Release o_ready -> remaining 32 accepted, done asserted.
- rresp=2 on beat 5 of burst 0, rid=1 -> buf_error=2'b01; buf_error_info beat index=5, rid=1, rresp=2; transfer still completes with done.
- rd_len=3, rlast on beat index 2 -> buf_error[1]=1; next burst's burst_beat restarts at 0.
- Start with total=0 -> buf_done_pulse one cycle later, m_axi_rready stays 0. Second start mid-RUN ignored. rst asserted mid-RUN -> all outputs 0, no done pulse.
- RDBUF_STALL_CNT_EN defined, o_ready=0, 10 stalled rvalid cycles -> stall_count=10; undefined build -> stall_count=0.
